alu_mdu: RTL

- Multi-cycle successor to the single-cycle CPU ALU, parametrised in WIDTH.
- Keeps the existing 11 combinational operations.
- Adds iterative multiply (shift-add) and divide (restoring) operations.
- Wrapped in a valid/ready handshake with a registered result, so the EX stage can stall on long operations and flush on branch mispredict.

---
 rtl/alu_mdu_pkg.sv | 32 +++
 rtl/alu_mdu_if.sv | 24 ++
 rtl/alu_mdu_core.sv | 90 +++++++++
 rtl/alu_mdu.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_mdu_pkg.sv
// Shared opcode encodings, FSM state type and opcode classification for the
// multi-cycle ALU/MDU.
package alu_pkg;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_EQ    = 4'b0010;
   localparam logic [3:0] ALU_SLTU  = 4'b0011;
   localparam logic [3:0] ALU_SLT   = 4'b0100;
   localparam logic [3:0] ALU_AND   = 4'b0101;
   localparam logic [3:0] ALU_OR    = 4'b0110;
   localparam logic [3:0] ALU_XOR   = 4'b0111;
   localparam logic [3:0] ALU_SRL   = 4'b1000;
   localparam logic [3:0] ALU_SLL   = 4'b1001;
   localparam logic [3:0] ALU_SRA   = 4'b1010;
   localparam logic [3:0] ALU_MUL   = 4'b1011;
   localparam logic [3:0] ALU_MULHU = 4'b1100;
   localparam logic [3:0] ALU_DIVU  = 4'b1101;
   localparam logic [3:0] ALU_REMU  = 4'b1110;
   localparam logic [3:0] ALU_DIV   = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic is_iter(input logic [3:0] func);
      return func >= ALU_MUL;
   endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bundle between the EX stage and the ALU/MDU.
interface alu_mdu_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_func;
   logic [WIDTH-1:0] alu_src1;
   logic [WIDTH-1:0] alu_src2;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_ans;
   logic             alu_of;
   logic             busy;

   modport master (
      output in_valid, alu_func, alu_src1, alu_src2, flush, out_ready,
      input  in_ready, out_valid, alu_ans, alu_of, busy
   );

   modport slave (
      input  in_valid, alu_func, alu_src1, alu_src2, flush, out_ready,
      output in_ready, out_valid, alu_ans, alu_of, busy
   );
endinterface

// File: rtl/alu_mdu_core.sv
// Iterative datapath: shift-add multiply or restoring divide, one bit per cycle.
module alu_mdu_core #(parameter int WIDTH = 32) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start,
   input  logic               flush,
   input  logic               div_mode,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic               done,
   output logic [2*WIDTH-1:0] prod_nxt,
   output logic [WIDTH-1:0]   rem_nxt
);
   localparam int CW = $clog2(WIDTH+1);

   logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
   logic [WIDTH:0]     rem_q, rem_d, rem_step, add_sum;
   logic [WIDTH+1:0]   shifted, diff;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               div_q, div_d, run_q, run_d, last;
   logic [CW-1:0]      cnt_q, cnt_d;

   // In divide mode the low half of prod_q holds the dividend shifting out and
   // the quotient shifting in; the high half is idle.
   always_comb begin
      add_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
      shifted = {rem_q, prod_q[WIDTH-1]};
      diff    = shifted - {2'b00, opb_q};
      if (div_q) begin
         if (diff[WIDTH+1]) begin
            rem_step  = shifted[WIDTH:0];
            prod_step = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], 1'b0};
         end else begin
            rem_step  = diff[WIDTH:0];
            prod_step = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], 1'b1};
         end
      end else begin
         rem_step  = rem_q;
         prod_step = {add_sum, prod_q[WIDTH-1:1]};
      end
   end

   assign last     = run_q && (cnt_q == CW'(WIDTH-1));
   assign done     = last && !flush;
   assign prod_nxt = prod_step;
   assign rem_nxt  = rem_step[WIDTH-1:0];

   always_comb begin
      prod_d = prod_q;
      rem_d  = rem_q;
      opb_d  = opb_q;
      div_d  = div_q;
      run_d  = run_q;
      cnt_d  = cnt_q;
      if (flush) begin
         run_d = 1'b0;
         cnt_d = '0;
      end else if (start) begin
         prod_d = {{WIDTH{1'b0}}, op_a};
         rem_d  = '0;
         opb_d  = op_b;
         div_d  = div_mode;
         run_d  = 1'b1;
         cnt_d  = '0;
      end else if (run_q) begin
         prod_d = prod_step;
         rem_d  = rem_step;
         run_d  = !last;
         cnt_d  = last ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         prod_q <= '0;
         rem_q  <= '0;
         opb_q  <= '0;
         div_q  <= 1'b0;
         run_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         prod_q <= prod_d;
         rem_q  <= rem_d;
         opb_q  <= opb_d;
         div_q  <= div_d;
         run_q  <= run_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: rtl/alu_mdu.sv
// Multi-cycle ALU/MDU: single-pass ops, iterative mul/div, valid/ready wrapper.
//   state  | meaning
//   S_IDLE | ready for a request
//   S_CALC | iterative datapath running, one bit per cycle
//   S_DONE | result held until the consumer takes it
module alu_mdu import alu_pkg::*; #(parameter int WIDTH = 32) (
   input logic       clk,
   input logic       rstn,
   alu_mdu_if.slave  bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   ans_q, ans_d, fast_ans, iter_ans, a, b, op_a, op_b, quo;
   logic               of_q, of_d, fast_of, bypass, neg_q, neg_d;
   logic [3:0]         func_q, func_d;
   logic [SHW-1:0]     shamt;
   logic               core_start, core_done, div_mode;
   logic [2*WIDTH-1:0] prod_nxt;
   logic [WIDTH-1:0]   rem_nxt;

   assign a     = bus.alu_src1;
   assign b     = bus.alu_src2;
   assign shamt = b[SHW-1:0];

   // Divide-by-zero and the one signed-divide overflow never enter the datapath.
   always_comb begin
      fast_ans = '0;
      fast_of  = 1'b0;
      bypass   = !is_iter(bus.alu_func);
      case (bus.alu_func)
         ALU_ADD: begin
            fast_ans = a + b;
            fast_of  = (a[WIDTH-1] == b[WIDTH-1]) && (fast_ans[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            fast_ans = a - b;
            fast_of  = (a[WIDTH-1] != b[WIDTH-1]) && (fast_ans[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_EQ:   fast_ans = WIDTH'(a == b);
         ALU_SLTU: fast_ans = WIDTH'(a < b);
         ALU_SLT:  fast_ans = WIDTH'($signed(a) < $signed(b));
         ALU_AND:  fast_ans = a & b;
         ALU_OR:   fast_ans = a | b;
         ALU_XOR:  fast_ans = a ^ b;
         ALU_SRL:  fast_ans = a >> shamt;
         ALU_SLL:  fast_ans = a << shamt;
         ALU_SRA:  fast_ans = WIDTH'($signed(a) >>> shamt);
         ALU_DIVU: if (b == '0) begin fast_ans = '1; bypass = 1'b1; end
         ALU_REMU: if (b == '0) begin fast_ans = a;  bypass = 1'b1; end
         ALU_DIV: begin
            if (b == '0) begin
               fast_ans = '1;
               bypass   = 1'b1;
            end else if (a == MIN_NEG && b == '1) begin
               fast_ans = MIN_NEG;
               fast_of  = 1'b1;
               bypass   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign op_a       = (bus.alu_func == ALU_DIV && a[WIDTH-1]) ? WIDTH'(0) - a : a;
   assign op_b       = (bus.alu_func == ALU_DIV && b[WIDTH-1]) ? WIDTH'(0) - b : b;
   assign div_mode   = bus.alu_func >= ALU_DIVU;
   assign core_start = (state_q == S_IDLE) && bus.in_valid && !bus.flush && !bypass;

   alu_mdu_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .rstn     (rstn),
      .start    (core_start),
      .flush    (bus.flush),
      .div_mode (div_mode),
      .op_a     (op_a),
      .op_b     (op_b),
      .done     (core_done),
      .prod_nxt (prod_nxt),
      .rem_nxt  (rem_nxt)
   );

   assign quo = prod_nxt[WIDTH-1:0];

   always_comb begin
      case (func_q)
         ALU_MUL:   iter_ans = prod_nxt[WIDTH-1:0];
         ALU_MULHU: iter_ans = prod_nxt[2*WIDTH-1:WIDTH];
         ALU_REMU:  iter_ans = rem_nxt;
         ALU_DIV:   iter_ans = neg_q ? WIDTH'(0) - quo : quo;
         default:   iter_ans = quo;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ans_d   = ans_q;
      of_d    = of_q;
      func_d  = func_q;
      neg_d   = neg_q;
      if (bus.flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (bus.in_valid) begin
               if (bypass) begin
                  ans_d   = fast_ans;
                  of_d    = fast_of;
                  state_d = S_DONE;
               end else begin
                  func_d  = bus.alu_func;
                  neg_d   = (bus.alu_func == ALU_DIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
                  state_d = S_CALC;
               end
            end
            S_CALC: if (core_done) begin
               ans_d   = iter_ans;
               of_d    = 1'b0;
               state_d = S_DONE;
            end
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         ans_q   <= '0;
         of_q    <= 1'b0;
         func_q  <= ALU_ADD;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ans_q   <= ans_d;
         of_q    <= of_d;
         func_q  <= func_d;
         neg_q   <= neg_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q == S_CALC);
   assign bus.alu_ans   = ans_q;
   assign bus.alu_of    = of_q;
endmodule
